id_ex_stage: RTL and testbench

- Pipeline register between decode/register-file read and the execute-stage ALU.
- Captures the decoded operation, register operands, immediate and destination info, and presents them to the ALU with a valid/ready handshake.
- Supports stall (downstream backpressure) and flush (branch redirect).
- Resolves RAW hazards by forwarding results from the EX/MEM and MEM/WB stages onto the operand outputs.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/forward_unit.sv | 26 ++
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU operation codes and the
// forwarding-source select used by the ID/EX pipeline register.
package cpu_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Per-source forwarding selector: picks EX/MEM over MEM/WB when either is
// writing the register being read; x0 is never forwarded.
module forward_unit
    import cpu_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              exm_reg_write_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    output fwd_sel_t          sel_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives sel_o and no latch is inferred.
        sel_o = FWD_REG;
        if (exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == src_i)) begin
            sel_o = FWD_EXM;
        end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and operand forwarding.
// Macro ID_EX_FWD_EN enables forwarding; without it a raw_hazard output is exported instead.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic [2:0]        in_alu_ctrl,
    input  logic              in_alu_src,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   ALUop1,
    output logic [XLEN-1:0]   RegOp2,
    output logic [2:0]        ALUctrl,
    output logic              ALUsrc,
    output logic [XLEN-1:0]   ImmOp,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_result
`ifndef ID_EX_FWD_EN
    ,
    output logic              raw_hazard
`endif
);

    logic              valid_q, valid_d;
    logic              capture;
    logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic              reg_write_q, alu_src_q;
    logic [2:0]        alu_ctrl_q;
    fwd_sel_t          sel_rs1, sel_rs2;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Flush beats capture; an un-consumed entry holds, a consumed one drains.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            alu_ctrl_q  <= ALU_ADD;
        end else if (capture) begin
            rs1_data_q  <= in_rs1_data;
            rs2_data_q  <= in_rs2_data;
            imm_q       <= in_imm;
            rs1_q       <= in_rs1;
            rs2_q       <= in_rs2;
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
            alu_src_q   <= in_alu_src;
            alu_ctrl_q  <= in_alu_ctrl;
        end
    end

    assign out_valid     = valid_q;
    assign ALUctrl       = alu_ctrl_q;
    assign ALUsrc        = alu_src_q;
    assign ImmOp         = imm_q;
    assign out_rd        = rd_q;
    assign out_reg_write = reg_write_q && valid_q;

    forward_unit #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .src_i           (rs1_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .sel_o           (sel_rs1)
    );

    forward_unit #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .src_i           (rs2_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .sel_o           (sel_rs2)
    );

`ifdef ID_EX_FWD_EN
    // Operand muxes follow the live bypass buses, so a stalled entry picks up late results.
    always_comb begin
        ALUop1 = rs1_data_q;
        case (sel_rs1)
            FWD_EXM: ALUop1 = exm_result;
            FWD_WB:  ALUop1 = wb_result;
            default: ALUop1 = rs1_data_q;
        endcase
    end

    always_comb begin
        RegOp2 = rs2_data_q;
        case (sel_rs2)
            FWD_EXM: RegOp2 = exm_result;
            FWD_WB:  RegOp2 = wb_result;
            default: RegOp2 = rs2_data_q;
        endcase
    end
`else
    logic unused_results;

    assign ALUop1         = rs1_data_q;
    assign RegOp2         = rs2_data_q;
    assign raw_hazard     = valid_q && ((sel_rs1 != FWD_REG) || (sel_rs2 != FWD_REG));
    assign unused_results = ^{exm_result, wb_result};
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven handshake vectors plus
// hand-written forwarding/hazard, x0 guard and async-reset sequences.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_reg_write, in_alu_src;
    logic [2:0]  in_alu_ctrl;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] ALUop1, RegOp2, ImmOp;
    logic [2:0]  ALUctrl;
    logic        ALUsrc;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        exm_reg_write, wb_reg_write;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_result, wb_result;
`ifndef ID_EX_FWD_EN
    logic        raw_hazard;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_alu_ctrl   (in_alu_ctrl),
        .in_alu_src    (in_alu_src),
        .in_imm        (in_imm),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALUop1        (ALUop1),
        .RegOp2        (RegOp2),
        .ALUctrl       (ALUctrl),
        .ALUsrc        (ALUsrc),
        .ImmOp         (ImmOp),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result)
`ifndef ID_EX_FWD_EN
        ,
        .raw_hazard    (raw_hazard)
`endif
    );

    typedef struct {
        logic        v, fl, ord;
        logic [2:0]  ctrl;
        logic [31:0] a, b, imm;
        logic [4:0]  rd;
        logic        rw, src;
        logic        exp_rdy, exp_ov;
        logic [2:0]  exp_ctrl;
        logic [31:0] exp_a, exp_b, exp_imm;
        logic [4:0]  exp_rd;
        logic        exp_rw, exp_src;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic src);
        in_valid     = 1'b1;
        in_alu_ctrl  = ctrl;
        in_rs1_data  = a;
        in_rs2_data  = b;
        in_imm       = imm;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = rd;
        in_reg_write = rw;
        in_alu_src   = src;
    endtask

    function automatic vec_t mk(input logic v, input logic fl, input logic ord,
                                input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                                input logic src, input logic exp_rdy, input logic exp_ov,
                                input logic [2:0] exp_ctrl, input logic [31:0] exp_a,
                                input logic [31:0] exp_b, input logic [31:0] exp_imm,
                                input logic [4:0] exp_rd, input logic exp_rw, input logic exp_src);
        vec_t r;
        r.v = v; r.fl = fl; r.ord = ord; r.ctrl = ctrl; r.a = a; r.b = b; r.imm = imm;
        r.rd = rd; r.rw = rw; r.src = src; r.exp_rdy = exp_rdy; r.exp_ov = exp_ov;
        r.exp_ctrl = exp_ctrl; r.exp_a = exp_a; r.exp_b = exp_b; r.exp_imm = exp_imm;
        r.exp_rd = exp_rd; r.exp_rw = exp_rw; r.exp_src = exp_src;
        return r;
    endfunction

    initial begin
        // Payload fields are only compared on rows where out_valid is expected high.
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, ALU_SUB, 32'd10, 32'd3, 32'd0, 5'd7, 1'b1, 1'b0,
                      1'b1, 1'b1, ALU_SUB, 32'd10, 32'd3, 32'd0, 5'd7, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0,
                      1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, ALU_AND, 32'h55, 32'h0F, 32'h10, 5'd3, 1'b0, 1'b1,
                      1'b1, 1'b1, ALU_AND, 32'h55, 32'h0F, 32'h10, 5'd3, 1'b0, 1'b1);
        for (int i = 3; i < 7; i++) begin
            vecs[i] = mk(1'b1, 1'b0, 1'b0, ALU_OR, 32'd1, 32'd2, 32'd4, 5'd4, 1'b1, 1'b0,
                         1'b0, 1'b1, ALU_AND, 32'h55, 32'h0F, 32'h10, 5'd3, 1'b0, 1'b1);
        end
        vecs[7]  = mk(1'b1, 1'b0, 1'b1, ALU_OR, 32'd1, 32'd2, 32'd4, 5'd4, 1'b1, 1'b0,
                      1'b1, 1'b1, ALU_OR, 32'd1, 32'd2, 32'd4, 5'd4, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, ALU_SLT, 32'd9, 32'd9, 32'd9, 5'd9, 1'b1, 1'b1,
                      1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0,
                      1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, ALU_ADD, 32'd5, 32'd5, 32'd5, 5'd5, 1'b1, 1'b0,
                      1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1'b1, ALU_ADD, 32'h1234, 32'hFFFF_FFFF, 32'hFFFF_F800, 5'd31, 1'b1, 1'b1,
                      1'b1, 1'b1, ALU_ADD, 32'h1234, 32'hFFFF_FFFF, 32'hFFFF_F800, 5'd31, 1'b1, 1'b1);
        vecs[12] = mk(1'b1, 1'b0, 1'b1, ALU_SLT, 32'd7, 32'd8, 32'd0, 5'd1, 1'b0, 1'b0,
                      1'b1, 1'b1, ALU_SLT, 32'd7, 32'd8, 32'd0, 5'd1, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0,
                      1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_reg_write = 1'b0; in_alu_src = 1'b0; in_alu_ctrl = ALU_ADD;
        exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;

        // Reset state
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ALUctrl", {29'd0, ALUctrl}, 32'd0);
        check("rst_ALUsrc", {31'd0, ALUsrc}, 32'd0);
        check("rst_ImmOp", ImmOp, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_ALUop1", ALUop1, 32'd0);
        check("rst_RegOp2", RegOp2, 32'd0);
        check("rst_out_reg_write", {31'd0, out_reg_write}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table: handshake, stall, flush, back-to-back, immediate passthrough
        for (int i = 0; i < 14; i++) begin
            in_valid = vecs[i].v; flush = vecs[i].fl; out_ready = vecs[i].ord;
            in_alu_ctrl = vecs[i].ctrl; in_rs1_data = vecs[i].a; in_rs2_data = vecs[i].b;
            in_imm = vecs[i].imm; in_rd = vecs[i].rd; in_reg_write = vecs[i].rw;
            in_alu_src = vecs[i].src; in_rs1 = 5'd1; in_rs2 = 5'd2;
            #1;
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_rdy});
            step();
            check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
            check($sformatf("v%0d_out_reg_write", i), {31'd0, out_reg_write}, {31'd0, vecs[i].exp_rw});
`ifndef ID_EX_FWD_EN
            check($sformatf("v%0d_raw_hazard", i), {31'd0, raw_hazard}, 32'd0);
`endif
            if (vecs[i].exp_ov) begin
                check($sformatf("v%0d_ALUctrl", i), {29'd0, ALUctrl}, {29'd0, vecs[i].exp_ctrl});
                check($sformatf("v%0d_ALUop1", i), ALUop1, vecs[i].exp_a);
                check($sformatf("v%0d_RegOp2", i), RegOp2, vecs[i].exp_b);
                check($sformatf("v%0d_ImmOp", i), ImmOp, vecs[i].exp_imm);
                check($sformatf("v%0d_out_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].exp_rd});
                check($sformatf("v%0d_ALUsrc", i), {31'd0, ALUsrc}, {31'd0, vecs[i].exp_src});
            end
        end

        // Forward priority and x0 guard on a stalled entry (rs1=5, rs2=0)
        issue(ALU_ADD, 32'h11, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("fwd_hold_valid", {31'd0, out_valid}, 32'd1);
        exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'hAA;
        wb_reg_write = 1'b1;  wb_rd = 5'd5;  wb_result = 32'hBB;
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_exm_priority", ALUop1, 32'hAA);
`else
        check("nofwd_op1_both", ALUop1, 32'h11);
        check("hazard_both", {31'd0, raw_hazard}, 32'd1);
`endif
        exm_reg_write = 1'b0;
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_wb_only", ALUop1, 32'hBB);
`else
        check("nofwd_op1_wb", ALUop1, 32'h11);
        check("hazard_wb", {31'd0, raw_hazard}, 32'd1);
`endif
        wb_reg_write = 1'b0;
        #1;
        check("fwd_none_op1", ALUop1, 32'h11);
        exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'hFF;
        #1;
        check("x0_guard_RegOp2", RegOp2, 32'h0);
        check("x0_guard_ALUop1", ALUop1, 32'h11);
`ifndef ID_EX_FWD_EN
        check("x0_guard_hazard", {31'd0, raw_hazard}, 32'd0);
`endif

        // Drain, then confirm the hazard is qualified by out_valid
        exm_reg_write = 1'b0;
        out_ready = 1'b1;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
`ifndef ID_EX_FWD_EN
        wb_reg_write = 1'b1; wb_rd = 5'd5;
        #1;
        check("hazard_needs_valid", {31'd0, raw_hazard}, 32'd0);
        wb_reg_write = 1'b0;
`endif

        // Source-2 forwarding while ALUsrc=1 (rs1=0, rs2=6)
        issue(ALU_SLT, 32'h33, 32'h22, 32'h7, 5'd0, 5'd6, 5'd8, 1'b1, 1'b1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wb_reg_write = 1'b1; wb_rd = 5'd6; wb_result = 32'hCC;
        #1;
        check("src2_ALUsrc", {31'd0, ALUsrc}, 32'd1);
        check("src2_ImmOp", ImmOp, 32'h7);
        check("src2_ALUop1_x0", ALUop1, 32'h33);
`ifdef ID_EX_FWD_EN
        check("src2_fwd_wb", RegOp2, 32'hCC);
`else
        check("src2_nofwd", RegOp2, 32'h22);
        check("src2_hazard", {31'd0, raw_hazard}, 32'd1);
`endif
        exm_reg_write = 1'b1; exm_rd = 5'd6; exm_result = 32'hDD;
        #1;
`ifdef ID_EX_FWD_EN
        check("src2_fwd_exm", RegOp2, 32'hDD);
`else
        check("src2_nofwd_exm", RegOp2, 32'h22);
`endif
        exm_reg_write = 1'b0; wb_reg_write = 1'b0;

        // Async reset between edges while stalled
        step();
        check("pre_areset_valid", {31'd0, out_valid}, 32'd1);
        check("pre_areset_ctrl", {29'd0, ALUctrl}, {29'd0, ALU_SLT});
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {31'd0, out_valid}, 32'd0);
        check("areset_ctrl", {29'd0, ALUctrl}, 32'd0);
        check("areset_imm", ImmOp, 32'd0);
        check("areset_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
